// File: rtl/jtdsp16_sout_if.sv
// CPU-side register access and serial output pins of the DSP16 serial output unit.
interface jtdsp16_sout_if;
  logic [15:0] cpu_dout;
  logic [1:0]  cpu_addr;
  logic        sio_we;
  logic [15:0] sio_dout;
  logic        ock;
  logic        sio_do;
  logic        old;
  logic        ose;
  logic        obe;
  logic        obe_irq;

  modport master (
    output cpu_dout, cpu_addr, sio_we,
    input  sio_dout, ock, sio_do, old, ose, obe, obe_irq
  );

  modport slave (
    input  cpu_dout, cpu_addr, sio_we,
    output sio_dout, ock, sio_do, old, ose, obe, obe_irq
  );
endinterface

// File: rtl/jtdsp16_sout.sv
// DSP16 serial output unit: double-buffered SDX register, 8/16-bit words,
// MSB/LSB-first order, programmable bit-clock prescaler, overrun and empty irq.
module jtdsp16_sout #(
  parameter int unsigned DIV    = 12,
  parameter int unsigned PSW    = 3,
  parameter logic [3:0]  CTLRST = 4'h0
) (
  input  logic          clk,
  input  logic          rst,
  jtdsp16_sout_if.slave bus
);
  localparam int unsigned CW = $clog2(DIV) + PSW;
  localparam int unsigned DW = 16;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t        st;
  logic [3:0]    sioc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] period;
  logic [CW-1:0] half;
  logic          tick;
  logic [DW-1:0] obuf;
  logic [DW-1:0] shreg;
  logic [3:0]    bcnt;
  logic [3:0]    nb;
  logic [3:0]    wlast;
  logic [3:0]    idx;
  logic          w8;
  logic          lsbf;
  logic          ock_q;
  logic          do_q;
  logic          old_q;
  logic          ose_q;
  logic          obe_q;
  logic          irq_q;
  logic          ovf;
  logic [15:0]   dout_q;
  logic          wr_sdx;
  logic          wr_ctl;
  logic          wr_st;
  logic          load;
  logic          first_bit;
  logic          next_bit;

  // Register decode, prescaler period and shifter bit selection
  always_comb begin
    wr_sdx    = bus.sio_we && (bus.cpu_addr == 2'd0);
    wr_ctl    = bus.sio_we && (bus.cpu_addr == 2'd1);
    wr_st     = bus.sio_we && (bus.cpu_addr == 2'd2);
    period    = CW'(DIV) << sioc[3:2];
    half      = period >> 1;
    tick      = (cnt == period - CW'(1));
    cnt_nx    = (wr_ctl || tick) ? '0 : cnt + CW'(1);
    load      = tick && !obe_q && ((st == ST_IDLE) || (bcnt == 4'd0));
    first_bit = sioc[1] ? obuf[0] : (sioc[0] ? obuf[7] : obuf[15]);
    nb        = bcnt - 4'd1;
    wlast     = w8 ? 4'd7 : 4'd15;
    // LSB-first walks the index upwards as bcnt counts down
    idx       = lsbf ? (wlast - nb) : nb;
    next_bit  = shreg[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_IDLE;
      sioc   <= CTLRST;
      cnt    <= '0;
      obuf   <= '0;
      shreg  <= '0;
      bcnt   <= 4'd0;
      w8     <= 1'b0;
      lsbf   <= 1'b0;
      ock_q  <= 1'b0;
      do_q   <= 1'b0;
      old_q  <= 1'b0;
      ose_q  <= 1'b1;
      obe_q  <= 1'b1;
      irq_q  <= 1'b0;
      ovf    <= 1'b0;
      dout_q <= 16'd0;
    end else begin
      cnt   <= cnt_nx;
      ock_q <= (cnt_nx < half);
      old_q <= load;
      // obe only rises at a load that is not shadowed by a same-clk SDX write
      irq_q <= load && !wr_sdx;

      if (wr_ctl) sioc <= bus.cpu_dout[3:0];

      if (wr_sdx) obuf <= bus.cpu_dout;

      if (wr_sdx)    obe_q <= 1'b0;
      else if (load) obe_q <= 1'b1;

      if (wr_st)                              ovf <= 1'b0;
      else if (wr_sdx && !obe_q && !load)     ovf <= 1'b1;

      if (load) begin
        st    <= ST_SHIFT;
        shreg <= sioc[0] ? {8'd0, obuf[7:0]} : obuf;
        bcnt  <= sioc[0] ? 4'd7 : 4'd15;
        w8    <= sioc[0];
        lsbf  <= sioc[1];
        ose_q <= 1'b0;
        do_q  <= first_bit;
      end else if (tick) begin
        case (st)
          ST_SHIFT: begin
            if (bcnt != 4'd0) begin
              do_q <= next_bit;
              bcnt <= nb;
            end else begin
              st    <= ST_IDLE;
              ose_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      case (bus.cpu_addr)
        2'd1:    dout_q <= {12'd0, sioc};
        2'd2:    dout_q <= {13'd0, ovf, ose_q, obe_q};
        default: dout_q <= 16'd0;
      endcase
    end
  end

  assign bus.ock      = ock_q;
  assign bus.sio_do   = do_q;
  assign bus.old      = old_q;
  assign bus.ose      = ose_q;
  assign bus.obe      = obe_q;
  assign bus.obe_irq  = irq_q;
  assign bus.sio_dout = dout_q;
endmodule

// File: tb/tb_jtdsp16_sout.sv
// Bench for jtdsp16_sout: directed scenarios plus random words against a bit-sequence model.
module tb_jtdsp16_sout;
  localparam int unsigned DIV = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtdsp16_sout_if bus();

  jtdsp16_sout #(.DIV(DIV), .PSW(3), .CTLRST(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;
  int          irq_n = 0;
  logic        rx_q[$];
  int unsigned old_q[$];
  logic        exp_q[$];
  logic        ock_p = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: first bit at each load, then one bit per ock rising edge while shifting
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.old) begin
        rx_q.push_back(bus.sio_do);
        old_q.push_back(cyc);
      end else if (bus.ock && !ock_p && !bus.ose) begin
        rx_q.push_back(bus.sio_do);
      end
      if (bus.obe_irq) irq_n++;
    end
    ock_p = bus.ock;
  end

  function automatic void push_exp(input logic [15:0] w, input bit w8, input bit lsb);
    int n;
    n = w8 ? 8 : 16;
    for (int i = 0; i < n; i++) exp_q.push_back(lsb ? w[i] : w[n-1-i]);
  endfunction

  function automatic logic [31:0] pack_rx(input int base);
    logic [31:0] v;
    v = '0;
    for (int i = base; i < rx_q.size(); i++) v = {v[30:0], rx_q[i]};
    return v;
  endfunction

  function automatic logic [31:0] pack_exp();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < exp_q.size(); i++) v = {v[30:0], exp_q[i]};
    return v;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cpu_addr = a;
    bus.cpu_dout = d;
    bus.sio_we   = 1'b1;
    @(negedge clk);
    bus.sio_we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.cpu_addr = a;
    @(negedge clk);
    d = bus.sio_dout;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.ose && bus.obe) && k < lim);
    n_cmp++;
    if (!(bus.ose && bus.obe)) begin
      $display("FAIL %s_idle timeout ose=%b obe=%b want 1/1", nm, bus.ose, bus.obe);
      n_bad++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    bus.cpu_dout = '0;
    bus.cpu_addr = '0;
    bus.sio_we   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.ock !== 1'b0)     begin $display("FAIL rst_ock got %b want 0", bus.ock); n_bad++; end
    n_cmp++; if (bus.sio_do !== 1'b0)  begin $display("FAIL rst_do got %b want 0", bus.sio_do); n_bad++; end
    n_cmp++; if (bus.old !== 1'b0)     begin $display("FAIL rst_old got %b want 0", bus.old); n_bad++; end
    n_cmp++; if (bus.ose !== 1'b1)     begin $display("FAIL rst_ose got %b want 1", bus.ose); n_bad++; end
    n_cmp++; if (bus.obe !== 1'b1)     begin $display("FAIL rst_obe got %b want 1", bus.obe); n_bad++; end
    n_cmp++; if (bus.obe_irq !== 1'b0) begin $display("FAIL rst_irq got %b want 0", bus.obe_irq); n_bad++; end
    rst = 1'b0;
    rd(2'd2, d);
    n_cmp++; if (d !== 16'h0003) begin $display("FAIL rst_status got %h want 0003", d); n_bad++; end
    rd(2'd1, d);
    n_cmp++; if (d !== 16'h0000) begin $display("FAIL rst_sioc got %h want 0000", d); n_bad++; end
    n_cmp++; if (irq_n != 0) begin $display("FAIL rst_irq_release got %0d want 0", irq_n); n_bad++; end
  endtask

  task automatic test_msb16();
    int base, ob, irq0;
    int unsigned wcyc;
    logic [15:0] d;
    wr(2'd1, 16'h0000);
    base = rx_q.size(); ob = old_q.size(); irq0 = irq_n;
    exp_q.delete(); push_exp(16'hA5C3, 1'b0, 1'b0);
    wr(2'd0, 16'hA5C3);
    wcyc = cyc;
    wait_idle("msb16", 40 * DIV);
    n_cmp++;
    if (pack_rx(base) !== pack_exp() || rx_q.size() - base != exp_q.size()) begin
      $display("FAIL msb16_bits got %h (%0d) want %h (%0d)", pack_rx(base), rx_q.size() - base, pack_exp(), exp_q.size());
      n_bad++;
    end
    n_cmp++;
    if (old_q.size() - ob != 1) begin $display("FAIL msb16_old got %0d want 1", old_q.size() - ob); n_bad++; end
    else begin
      n_cmp++;
      if (old_q[ob] - wcyc > DIV) begin $display("FAIL msb16_latency got %0d want <=%0d", old_q[ob] - wcyc, DIV); n_bad++; end
    end
    n_cmp++;
    if (irq_n - irq0 != 1) begin $display("FAIL msb16_irq got %0d want 1", irq_n - irq0); n_bad++; end
    rd(2'd2, d);
    n_cmp++; if (d !== 16'h0003) begin $display("FAIL msb16_status got %h want 0003", d); n_bad++; end
  endtask

  task automatic test_lsb8();
    int base;
    logic [15:0] d;
    wr(2'd1, 16'h0003);
    rd(2'd1, d);
    n_cmp++; if (d !== 16'h0003) begin $display("FAIL lsb8_sioc got %h want 0003", d); n_bad++; end
    base = rx_q.size();
    exp_q.delete(); push_exp(16'h00B4, 1'b1, 1'b1);
    wr(2'd0, 16'h7EB4);
    wait_idle("lsb8", 40 * DIV);
    n_cmp++;
    if (pack_rx(base) !== pack_exp() || rx_q.size() - base != exp_q.size()) begin
      $display("FAIL lsb8_bits got %h (%0d) want %h (%0d)", pack_rx(base), rx_q.size() - base, pack_exp(), exp_q.size());
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    int base, ob, k;
    logic [15:0] d;
    wr(2'd1, 16'h0000);
    base = rx_q.size(); ob = old_q.size();
    exp_q.delete(); push_exp(16'h1234, 1'b0, 1'b0); push_exp(16'h5678, 1'b0, 1'b0);
    wr(2'd0, 16'h1234);
    k = 0;
    while (old_q.size() == ob && k < 4 * DIV) begin @(negedge clk); k++; end
    n_cmp++;
    if (old_q.size() == ob) begin $display("FAIL b2b_first_load timeout got 0 loads want 1"); n_bad++; end
    wr(2'd0, 16'h5678);
    wait_idle("b2b", 80 * DIV);
    n_cmp++;
    if (pack_rx(base) !== pack_exp() || rx_q.size() - base != exp_q.size()) begin
      $display("FAIL b2b_bits got %h (%0d) want %h (%0d)", pack_rx(base), rx_q.size() - base, pack_exp(), exp_q.size());
      n_bad++;
    end
    n_cmp++;
    if (old_q.size() - ob != 2) begin $display("FAIL b2b_old got %0d want 2", old_q.size() - ob); n_bad++; end
    else begin
      n_cmp++;
      if (old_q[ob+1] - old_q[ob] != 16 * DIV) begin
        $display("FAIL b2b_gap got %0d want %0d", old_q[ob+1] - old_q[ob], 16 * DIV); n_bad++;
      end
    end
    rd(2'd2, d);
    n_cmp++; if (d !== 16'h0003) begin $display("FAIL b2b_status got %h want 0003", d); n_bad++; end
  endtask

  task automatic test_overrun();
    int base, ob;
    logic [15:0] d;
    wr(2'd1, 16'h0000);
    base = rx_q.size(); ob = old_q.size();
    exp_q.delete(); push_exp(16'h2222, 1'b0, 1'b0);
    wr(2'd0, 16'h1111);
    wr(2'd0, 16'h2222);
    rd(2'd2, d);
    n_cmp++; if (d !== 16'h0006) begin $display("FAIL ovf_status_pre got %h want 0006", d); n_bad++; end
    wait_idle("ovf", 40 * DIV);
    n_cmp++;
    if (pack_rx(base) !== pack_exp() || rx_q.size() - base != exp_q.size()) begin
      $display("FAIL ovf_bits got %h (%0d) want %h (%0d)", pack_rx(base), rx_q.size() - base, pack_exp(), exp_q.size());
      n_bad++;
    end
    n_cmp++;
    if (old_q.size() - ob != 1) begin $display("FAIL ovf_old got %0d want 1", old_q.size() - ob); n_bad++; end
    rd(2'd2, d);
    n_cmp++; if (d !== 16'h0007) begin $display("FAIL ovf_sticky got %h want 0007", d); n_bad++; end
    wr(2'd2, 16'hFFFF);
    rd(2'd2, d);
    n_cmp++; if (d !== 16'h0003) begin $display("FAIL ovf_clear got %h want 0003", d); n_bad++; end
  endtask

  task automatic test_ratio();
    int k, hi, lo;
    logic p;
    wr(2'd1, 16'h0008);
    k = 0;
    do begin p = bus.ock; @(negedge clk); k++; end while (!(bus.ock && !p) && k < 200);
    hi = 0;
    while (bus.ock && hi < 200) begin hi++; @(negedge clk); end
    lo = 0;
    while (!bus.ock && lo < 200) begin lo++; @(negedge clk); end
    n_cmp++; if (hi != 24) begin $display("FAIL ratio_high got %0d want 24", hi); n_bad++; end
    n_cmp++; if (lo != 24) begin $display("FAIL ratio_low got %0d want 24", lo); n_bad++; end
    repeat (10) @(negedge clk);
    wr(2'd1, 16'h0008);
    hi = 0;
    while (bus.ock && hi < 200) begin hi++; @(negedge clk); end
    n_cmp++; if (hi != 24) begin $display("FAIL ratio_restart got %0d want 24", hi); n_bad++; end
  endtask

  task automatic test_random();
    int base, irq0;
    logic [15:0] w;
    logic [3:0] c;
    for (int it = 0; it < 8; it++) begin
      c = {2'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      w = 16'($urandom);
      wr(2'd1, {12'd0, c});
      base = rx_q.size(); irq0 = irq_n;
      exp_q.delete(); push_exp(w, c[0], c[1]);
      wr(2'd0, w);
      wait_idle("rand", 60 * DIV);
      n_cmp++;
      if (pack_rx(base) !== pack_exp() || rx_q.size() - base != exp_q.size()) begin
        $display("FAIL rand%0d_bits sioc=%h word=%h got %h (%0d) want %h (%0d)", it, c, w,
                 pack_rx(base), rx_q.size() - base, pack_exp(), exp_q.size());
        n_bad++;
      end
      n_cmp++;
      if (irq_n - irq0 != 1) begin $display("FAIL rand%0d_irq got %0d want 1", it, irq_n - irq0); n_bad++; end
    end
  endtask

  task automatic test_rst_mid();
    int base, ob, k;
    logic [15:0] d;
    wr(2'd1, 16'h0002);
    base = rx_q.size();
    wr(2'd0, 16'hFFFF);
    wr(2'd0, 16'hFFFF);
    k = 0;
    while (rx_q.size() - base < 7 && k < 20 * DIV) begin @(negedge clk); k++; end
    n_cmp++;
    if (rx_q.size() - base < 7) begin $display("FAIL rstmid_reach got %0d bits want 7", rx_q.size() - base); n_bad++; end
    n_cmp++; if (bus.sio_do !== 1'b1) begin $display("FAIL rstmid_pre_do got %b want 1", bus.sio_do); n_bad++; end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ose !== 1'b1)    begin $display("FAIL rstmid_ose got %b want 1", bus.ose); n_bad++; end
    n_cmp++; if (bus.obe !== 1'b1)    begin $display("FAIL rstmid_obe got %b want 1", bus.obe); n_bad++; end
    n_cmp++; if (bus.sio_do !== 1'b0) begin $display("FAIL rstmid_do got %b want 0", bus.sio_do); n_bad++; end
    n_cmp++; if (bus.ock !== 1'b0)    begin $display("FAIL rstmid_ock got %b want 0", bus.ock); n_bad++; end
    rst = 1'b0;
    base = rx_q.size(); ob = old_q.size();
    rd(2'd1, d);
    n_cmp++; if (d !== 16'h0000) begin $display("FAIL rstmid_sioc got %h want 0000", d); n_bad++; end
    rd(2'd2, d);
    n_cmp++; if (d !== 16'h0003) begin $display("FAIL rstmid_status got %h want 0003", d); n_bad++; end
    repeat (3 * DIV) @(negedge clk);
    n_cmp++;
    if (rx_q.size() != base || old_q.size() != ob) begin
      $display("FAIL rstmid_dropped got %0d bits %0d loads want 0 0", rx_q.size() - base, old_q.size() - ob);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_msb16();
    test_lsb8();
    test_back_to_back();
    test_overrun();
    test_ratio();
    test_random();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
